present_arbiter: RTL and testbench

- Shares one present80_core between two requesters (Pico-side register blocks 0 and 1) with round-robin arbitration.
- Per job: latches the winner's plaintext and key, issues a one-cycle start, waits for core done, then returns the ciphertext on a valid/ack handshake.
- Sits between the crypto port-decode registers and the PRESENT core, replacing direct start/pt/key wiring.

---
 rtl/present_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_present_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/present_arbiter.sv
// Round-robin arbiter sharing one PRESENT-80 core between two requesters.
// Latches the winner's plaintext/key, pulses core_start, waits for core_done
// and returns the ciphertext on a per-requester valid/ack handshake.
// Optional build macro PRESENT_ARB_TIMEOUT_EN adds a WAIT-state watchdog.
module present_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [63:0]      pt0,
  input  logic [63:0]      pt1,
  input  logic [79:0]      key0,
  input  logic [79:0]      key1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rsp_valid0,
  output logic             rsp_valid1,
  input  logic             rsp_ack0,
  input  logic             rsp_ack1,
  output logic [63:0]      ct0,
  output logic [63:0]      ct1,
  output logic             err0,
  output logic             err1,
  output logic             core_start,
  output logic [63:0]      core_pt,
  output logic [79:0]      core_key,
  input  logic             core_busy,
  input  logic             core_done,
  input  logic [63:0]      core_ct,
  output logic             busy,
  output logic [CNT_W-1:0] job_count
);

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StWait, StResp} state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             rr_last_q, rr_last_d;
  logic [63:0]      core_pt_q, core_pt_d;
  logic [79:0]      core_key_q, core_key_d;
  logic [63:0]      ct0_q, ct0_d, ct1_q, ct1_d;
  logic             err0_q, err0_d, err1_q, err1_d;
  logic [CNT_W-1:0] job_count_q, job_count_d;
  logic             win;
  logic             timeout_hit;
  logic             unused_core_busy;

  // core_busy is observational only
  assign unused_core_busy = core_busy;

`ifdef PRESENT_ARB_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;

  assign timeout_hit = (state_q == StWait) && (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));

  // Watchdog counts WAIT cycles; cleared in START so it is zero on WAIT entry
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == StStart) begin
      tmo_cnt_d = '0;
    end else if (state_q == StWait) begin
      tmo_cnt_d = tmo_cnt_q + TmoW'(1);
    end
  end

  // Watchdog counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic [31:0] unused_timeout_cycles;

  assign unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit           = 1'b0;
`endif

  // Winner: sole requester, or on a tie the side that did not win last
  always_comb begin
    if (req0 && req1) begin
      win = ~rr_last_q;
    end else begin
      win = req1;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_last_d   = rr_last_q;
    core_pt_d   = core_pt_q;
    core_key_d  = core_key_q;
    ct0_d       = ct0_q;
    ct1_d       = ct1_q;
    err0_d      = err0_q;
    err1_d      = err1_q;
    job_count_d = job_count_q;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          state_d    = StLoad;
          owner_d    = win;
          rr_last_d  = win;
          core_pt_d  = win ? pt1 : pt0;
          core_key_d = win ? key1 : key0;
        end
      end
      StLoad:  state_d = StStart;
      StStart: state_d = StWait;
      StWait: begin
        // core_done has priority over a simultaneous watchdog expiry
        if (core_done || timeout_hit) begin
          state_d     = StResp;
          job_count_d = job_count_q + CNT_W'(1);
          if (owner_q) begin
            ct1_d  = core_done ? core_ct : 64'h0;
            err1_d = ~core_done;
          end else begin
            ct0_d  = core_done ? core_ct : 64'h0;
            err0_d = ~core_done;
          end
        end
      end
      StResp: begin
        if (owner_q ? rsp_ack1 : rsp_ack0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      rr_last_q   <= 1'b1;
      core_pt_q   <= '0;
      core_key_q  <= '0;
      ct0_q       <= '0;
      ct1_q       <= '0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      job_count_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_last_q   <= rr_last_d;
      core_pt_q   <= core_pt_d;
      core_key_q  <= core_key_d;
      ct0_q       <= ct0_d;
      ct1_q       <= ct1_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
      job_count_q <= job_count_d;
    end
  end

  // Handshake outputs decode straight from registered state, so reset clears them at once
  always_comb begin
    gnt0       = (state_q == StLoad) && !owner_q;
    gnt1       = (state_q == StLoad) && owner_q;
    rsp_valid0 = (state_q == StResp) && !owner_q;
    rsp_valid1 = (state_q == StResp) && owner_q;
    core_start = (state_q == StStart);
    busy       = (state_q != StIdle);
  end

  assign core_pt   = core_pt_q;
  assign core_key  = core_key_q;
  assign ct0       = ct0_q;
  assign ct1       = ct1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign job_count = job_count_q;

endmodule

// File: tb/tb_present_arbiter.sv
// Self-checking bench for present_arbiter with a behavioural PRESENT core stub.
module tb_present_arbiter;

  localparam int unsigned CntW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            req0, req1;
  logic [63:0]     pt0, pt1;
  logic [79:0]     key0, key1;
  logic            gnt0, gnt1;
  logic            rsp_valid0, rsp_valid1;
  logic            rsp_ack0, rsp_ack1;
  logic [63:0]     ct0, ct1;
  logic            err0, err1;
  logic            core_start;
  logic [63:0]     core_pt;
  logic [79:0]     core_key;
  logic            core_busy;
  logic            core_done;
  logic [63:0]     core_ct = 64'h0;
  logic            busy;
  logic [CntW-1:0] job_count;

  logic stub_done = 1'b0;
  logic inj_done  = 1'b0;
  logic stub_hang = 1'b0;
  int   stub_cnt  = 0;

  int checks = 0;
  int errors = 0;

  present_arbiter #(
    .TIMEOUT_CYCLES(8),
    .CNT_W         (CntW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .pt0       (pt0),
    .pt1       (pt1),
    .key0      (key0),
    .key1      (key1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rsp_valid0(rsp_valid0),
    .rsp_valid1(rsp_valid1),
    .rsp_ack0  (rsp_ack0),
    .rsp_ack1  (rsp_ack1),
    .ct0       (ct0),
    .ct1       (ct1),
    .err0      (err0),
    .err1      (err1),
    .core_start(core_start),
    .core_pt   (core_pt),
    .core_key  (core_key),
    .core_busy (core_busy),
    .core_done (core_done),
    .core_ct   (core_ct),
    .busy      (busy),
    .job_count (job_count)
  );

  always #5 clk = ~clk;

  // Known PRESENT-80 vectors; other inputs map to a simple pt/key mix
  function automatic logic [63:0] model_ct(input logic [63:0] p, input logic [79:0] k);
    if (p == 64'h0 && k == 80'h0) return 64'h5579C1387B228445;
    if (p == 64'h0 && k == '1) return 64'hE72C46C0F5945049;
    if (p == '1 && k == 80'h0) return 64'hA112FFC72F68417B;
    if (p == '1 && k == '1) return 64'h3333DCD3213210D2;
    return p ^ k[79:16];
  endfunction

  // Core stub: result is presented at start, done pulses three cycles later
  always @(negedge clk) begin
    if (!reset) begin
      stub_cnt  = 0;
      stub_done = 1'b0;
    end else begin
      stub_done = 1'b0;
      if (stub_cnt > 0) begin
        stub_cnt = stub_cnt - 1;
        if (stub_cnt == 0) stub_done = 1'b1;
      end
      if (core_start) begin
        core_ct = model_ct(core_pt, core_key);
        if (!stub_hang) stub_cnt = 3;
      end
    end
  end

  assign core_done = stub_done | inj_done;
  assign core_busy = (stub_cnt != 0);

  typedef struct {
    logic        r0;
    logic        r1;
    logic [63:0] p0;
    logic [79:0] k0;
    logic [63:0] p1;
    logic [79:0] k1;
    logic        exp_w;
    logic [63:0] exp_ct;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full job for requester w; request lines must already be set in IDLE
  task automatic do_job(input logic w, input logic [63:0] exp_ct, input logic exp_err,
                        input logic [CntW-1:0] exp_cnt);
    for (int n = 0; n < 20 && !(gnt0 || gnt1); n++) tick();
    chk("gnt_seen", 128'(gnt0 | gnt1), 128'(1));
    chk("gnt_side", 128'({gnt1, gnt0}), w ? 128'(2) : 128'(1));
    if (w) req1 = 1'b0;
    else req0 = 1'b0;
    tick();
    chk("start_after_gnt", 128'({core_start, gnt1, gnt0}), 128'(4));
    tick();
    chk("start_one_cycle", 128'(core_start), 128'(0));
    for (int n = 0; n < 40 && !(rsp_valid0 || rsp_valid1); n++) tick();
    chk("rsp_side", 128'({rsp_valid1, rsp_valid0}), w ? 128'(2) : 128'(1));
    chk("rsp_ct", w ? 128'(ct1) : 128'(ct0), 128'(exp_ct));
    chk("rsp_err", w ? 128'(err1) : 128'(err0), 128'(exp_err));
    chk("job_count", 128'(job_count), 128'(exp_cnt));
    repeat (3) tick();
    chk("rsp_hold", 128'({rsp_valid1, rsp_valid0, w ? ct1 : ct0}),
        128'({w, ~w, exp_ct}));
    if (w) rsp_ack1 = 1'b1;
    else rsp_ack0 = 1'b1;
    tick();
    rsp_ack0 = 1'b0;
    rsp_ack1 = 1'b0;
    chk("rsp_drop_idle", 128'({busy, rsp_valid1, rsp_valid0}), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] exp_ct0, exp_ct1;
    int          jobs;

    vecs[0] = '{1'b1, 1'b0, 64'h0, 80'h0, 64'h0, 80'h0, 1'b0, 64'h5579C1387B228445};
    vecs[1] = '{1'b0, 1'b1, 64'h0, 80'h0, 64'h0, '1, 1'b1, 64'hE72C46C0F5945049};
    vecs[2] = '{1'b1, 1'b1, '1, 80'h0, 64'h0, 80'h0, 1'b0, 64'hA112FFC72F68417B};
    vecs[3] = '{1'b1, 1'b1, 64'h0, 80'h0, '1, '1, 1'b1, 64'h3333DCD3213210D2};
    vecs[4] = '{1'b1, 1'b1, 64'h0, '1, 64'h0, 80'h0, 1'b0, 64'hE72C46C0F5945049};
    vecs[5] = '{1'b1, 1'b1, 64'h0, 80'h0, 64'h0, 80'h0, 1'b1, 64'h5579C1387B228445};
    vecs[6] = '{1'b0, 1'b1, 64'h0, 80'h0, '1, 80'h0, 1'b1, 64'hA112FFC72F68417B};
    vecs[7] = '{1'b1, 1'b1, '1, '1, 64'h0, 80'h0, 1'b0, 64'h3333DCD3213210D2};

    reset = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    pt0 = '0;
    pt1 = '0;
    key0 = '0;
    key1 = '0;
    rsp_ack0 = 1'b0;
    rsp_ack1 = 1'b0;
    exp_ct0 = '0;
    exp_ct1 = '0;
    jobs = 0;

    repeat (2) tick();
    chk("reset_ctl", 128'({gnt0, gnt1, rsp_valid0, rsp_valid1, core_start, busy, err0, err1}),
        128'(0));
    chk("reset_ct", 128'({ct0, ct1}), 128'(0));
    chk("reset_core_data", 128'({core_pt, core_key}), 128'(0));
    chk("reset_job_count", 128'(job_count), 128'(0));
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Table: sole requesters, ties alternating 0,1,0,1, and sole winner after a win
    for (int i = 0; i < 8; i++) begin
      req0 = vecs[i].r0;
      req1 = vecs[i].r1;
      pt0 = vecs[i].p0;
      key0 = vecs[i].k0;
      pt1 = vecs[i].p1;
      key1 = vecs[i].k1;
      jobs++;
      do_job(vecs[i].exp_w, vecs[i].exp_ct, 1'b0, CntW'(jobs));
      if (vecs[i].exp_w) exp_ct1 = vecs[i].exp_ct;
      else exp_ct0 = vecs[i].exp_ct;
      chk("ct0_held", 128'(ct0), 128'(exp_ct0));
      chk("ct1_held", 128'(ct1), 128'(exp_ct1));
    end
    req0 = 1'b0;
    req1 = 1'b0;

    // done during START ignored; req1 queued in WAIT; non-owner ack ignored
    stub_hang = 1'b1;
    pt0 = '1;
    key0 = '1;
    pt1 = 64'h0;
    key1 = 80'h0;
    req0 = 1'b1;
    tick();
    chk("seq_gnt0", 128'(gnt0), 128'(1));
    req0 = 1'b0;
    tick();
    chk("seq_start", 128'(core_start), 128'(1));
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    chk("done_in_start_ignored", 128'({busy, rsp_valid0}), 128'(2));
    req1 = 1'b1;
    repeat (2) tick();
    chk("wait_holds", 128'({busy, rsp_valid0, gnt1}), 128'(4));
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    jobs++;
    chk("seq_rsp", 128'({rsp_valid0, ct0}), 128'({1'b1, 64'h3333DCD3213210D2}));
    chk("seq_job_count", 128'(job_count), 128'(jobs));
    stub_hang = 1'b0;
    rsp_ack1 = 1'b1;
    repeat (2) tick();
    rsp_ack1 = 1'b0;
    chk("ack1_ignored", 128'({rsp_valid0, gnt1}), 128'(2));
    rsp_ack0 = 1'b1;
    tick();
    rsp_ack0 = 1'b0;
    chk("ack_edge_idle", 128'({busy, rsp_valid0, gnt1}), 128'(0));
    tick();
    chk("req1_after_ack", 128'(gnt1), 128'(1));
    jobs++;
    do_job(1'b1, 64'h5579C1387B228445, 1'b0, CntW'(jobs));
    chk("seq_ct0_held", 128'(ct0), 128'(64'h3333DCD3213210D2));

`ifdef PRESENT_ARB_TIMEOUT_EN
    // Core never finishes: watchdog returns zero with err
    stub_hang = 1'b1;
    pt0 = 64'h0;
    key0 = 80'h0;
    req0 = 1'b1;
    jobs++;
    do_job(1'b0, 64'h0, 1'b1, CntW'(jobs));
    // done on the expiry cycle wins
    pt0 = '1;
    key0 = 80'h0;
    req0 = 1'b1;
    tick();
    chk("tmo_gnt0", 128'(gnt0), 128'(1));
    req0 = 1'b0;
    tick();
    tick();
    repeat (7) tick();
    chk("tmo_still_wait", 128'({busy, rsp_valid0}), 128'(2));
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    jobs++;
    chk("tmo_done_wins", 128'({rsp_valid0, err0, ct0}),
        128'({1'b1, 1'b0, 64'hA112FFC72F68417B}));
    chk("tmo_job_count", 128'(job_count), 128'(jobs));
    rsp_ack0 = 1'b1;
    tick();
    rsp_ack0 = 1'b0;
    stub_hang = 1'b0;
`endif

    // Asynchronous reset while in WAIT
    pt0 = 64'h0;
    key0 = 80'h0;
    req0 = 1'b1;
    tick();
    chk("rst_seq_gnt0", 128'(gnt0), 128'(1));
    req0 = 1'b0;
    tick();
    tick();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_async_ctl", 128'({busy, core_start, gnt0, gnt1, rsp_valid0, rsp_valid1}),
        128'(0));
    chk("rst_async_data", 128'({job_count, ct0, core_pt}), 128'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    tick();
    pt0 = 64'h0;
    key0 = '1;
    req0 = 1'b1;
    do_job(1'b0, 64'hE72C46C0F5945049, 1'b0, CntW'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
